// File: rtl/store_align_unit_pkg.sv
// Shared types for the store-path aligner:
// size encodings and beat FSM states.
package store_align_unit_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT1,
    ST_BEAT2
  } st_e;

endpackage

// File: rtl/store_align_unit_lane_rotate_mask.sv
// Lane placement for stores: rotated data, double-width
// byte mask, word-crossing and bad-size flags.
module lane_rotate_mask
  import store_align_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTES  = DATA_W / 8,
  parameter int OFF_W  = $clog2(BYTES)
) (
  input  logic [OFF_W-1:0]   off,
  input  logic [1:0]         size,
  input  logic [DATA_W-1:0]  data,
  output logic [DATA_W-1:0]  rot_data,
  output logic [2*BYTES-1:0] mask,
  output logic               split,
  output logic               size_err
);

  logic [2*DATA_W-1:0] dbl;
  logic [2*BYTES-1:0]  ones;
  logic [3:0]          n;

  assign n = 4'd1 << size;

  // upper half of the shifted pair is the left rotation
  assign dbl      = {data, data} << {off, 3'b000};
  assign rot_data = dbl[2*DATA_W-1:DATA_W];

  assign ones = ~({(2*BYTES){1'b1}} << n);
  assign mask = ones << off;

  assign size_err = int'(n) > BYTES;
  assign split    = !size_err && (int'(off) + int'(n) > BYTES);

endmodule

// File: rtl/store_align_unit.sv
// Store aligner: places register data on memory byte lanes,
// splitting or rejecting word-crossing stores.
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [DATA_W/8-1:0] mem_we,
  output logic              err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  st_e                state;
  logic               split_q;
  logic [BYTES-1:0]   hi_we;
  logic [DATA_W-1:0]  rot_data;
  logic [2*BYTES-1:0] mask;
  logic               split;
  logic               size_err;
  logic               last_held;
  logic               accept;
  logic               reject;
  logic               allow;
  logic [ADDR_W-1:0]  base;

  lane_rotate_mask #(
    .DATA_W (DATA_W)
  ) u_lrm (
    .off      (req_addr[OFF_W-1:0]),
    .size     (req_size),
    .data     (req_data),
    .rot_data (rot_data),
    .mask     (mask),
    .split    (split),
    .size_err (size_err)
  );

  assign allow = (ALLOW_MISALIGNED != 0);
  assign base  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign last_held = (state == ST_BEAT2) ||
                     (state == ST_BEAT1 && !split_q);
  assign req_ready = (state == ST_IDLE) ||
                     (mem_ready && last_held);
  assign accept    = req_valid && req_ready;
  assign reject    = size_err || (split && !allow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      split_q   <= 1'b0;
      hi_we     <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        unique case (1'b1)
          reject: begin
            err       <= 1'b1;
            mem_valid <= 1'b0;
            state     <= ST_IDLE;
          end
          default: begin
            mem_valid <= 1'b1;
            mem_addr  <= base;
            mem_data  <= rot_data;
            mem_we    <= mask[BYTES-1:0];
            hi_we     <= mask[2*BYTES-1:BYTES];
            split_q   <= split;
            state     <= ST_BEAT1;
          end
        endcase
      end else if (mem_valid && mem_ready) begin
        if (state == ST_BEAT1 && split_q) begin
          mem_addr <= mem_addr + ADDR_W'(BYTES);
          mem_we   <= hi_we;
          state    <= ST_BEAT2;
        end else begin
          mem_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      end
    end
  end

endmodule
